// File: rtl/aes_128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns state/round-key registers, does the
// initial AddRoundKey and steps an external round unit and key-expansion unit once per clock.
module aes_128_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic [127:0] rnd_state_o,
  output logic [127:0] rnd_key_o,
  output logic [7:0]   rnd_rcon_o,
  output logic         rnd_final_o,
  input  logic [127:0] next_key_i,
  input  logic [127:0] rnd_state_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_cipher,
  output logic         busy,
  output logic [3:0]   round_o
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q, key_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic         in_ready_q, out_valid_q, busy_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rcon_q      <= 8'h01;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid && in_ready_q) begin
          state_q    <= in_block ^ in_key;
          key_q      <= in_key;
          round_q    <= 4'd1;
          rcon_q     <= 8'h01;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          fsm_q      <= ROUND;
        end
        ROUND: begin
          state_q <= rnd_state_i;
          key_q   <= next_key_i;
          rcon_q  <= xtime(rcon_q);
          // round_o stays at NR through DONE so the sink can see which round finished
          if (round_q == 4'(NR)) begin
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          round_q     <= '0;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign round_o     = round_q;
  assign rnd_state_o = state_q;
  assign rnd_key_o   = key_q;
  assign rnd_rcon_o  = rcon_q;
  assign out_cipher  = state_q;
  assign rnd_final_o = (fsm_q == ROUND) && (round_q == 4'(NR));

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// Bench for aes_128_round_ctrl: models the round/key units and checks against a software AES-128.
module tb_aes_128_round_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid, in_ready, rnd_final_o, out_valid, out_ready, busy;
  logic [127:0] in_block, in_key, rnd_state_o, rnd_key_o, next_key_i, rnd_state_i, out_cipher;
  logic [7:0]   rnd_rcon_o;
  logic [3:0]   round_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc;
  logic [127:0] pa, ka, pb, kb, ea;
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_128_round_ctrl #(.NR(10)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o),
    .rnd_rcon_o(rnd_rcon_o), .rnd_final_o(rnd_final_o), .next_key_i(next_key_i),
    .rnd_state_i(rnd_state_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_cipher(out_cipher), .busy(busy), .round_o(round_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- software AES-128 (FIPS-197) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // multiplicative inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01, p = x, b;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, c0) ^ gmul(8'h03, c1) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(8'h02, c1) ^ gmul(8'h03, c2) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(8'h02, c2) ^ gmul(8'h03, c3);
        b[4*c+3] = gmul(8'h03, c0) ^ c1 ^ c2 ^ gmul(8'h02, c3);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key, k = key;
    for (int r = 1; r <= 10; r++) begin
      k = keyexp(k, rc_tab[r-1]);
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // external combinational round and key-expansion units
  always_comb begin
    next_key_i  = keyexp(rnd_key_o, rnd_rcon_o);
    rnd_state_i = aes_round(rnd_state_o, next_key_i, rnd_final_o);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after the DONE transition.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    in_valid = 1'b1; in_block = pt; in_key = key;
    chk("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0; in_block = rnd128(); in_key = rnd128();
    chk("state_after_accept", rnd_state_o, pt ^ key);
    chk("key_after_accept", rnd_key_o, key);
    for (int r = 1; r <= 10; r++) begin
      chk("round_o", round_o, 128'(r));
      chk("rcon", rnd_rcon_o, rc_tab[r-1]);
      chk("final", rnd_final_o, r == 10);
      chk("out_valid_early", out_valid, 1'b0);
      chk("in_ready_busy", in_ready, 1'b0);
      chk("busy_round", busy, 1'b1);
      in_block = rnd128(); next_key_unused();
      @(negedge clk);
    end
    chk("out_valid_done", out_valid, 1'b1);
    chk("cipher", out_cipher, exp);
    chk("round_o_done", round_o, 128'd10);
    chk("busy_done", busy, 1'b1);
  endtask

  task automatic next_key_unused();
    in_key = rnd128();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_round"}, round_o, 128'd0);
  endtask

  task automatic chk_reset_vals();
    chk_idle("rst");
    chk("rst_final", rnd_final_o, 1'b0);
    chk("rst_rcon", rnd_rcon_o, 8'h01);
    chk("rst_state", rnd_state_o, 128'd0);
    chk("rst_key", rnd_key_o, 128'd0);
    chk("rst_cipher", out_cipher, 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_block = '0; in_key = '0;
    #12;
    chk_reset_vals();
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B and App. C.1
    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32);
    @(negedge clk); chk_idle("idle_b");
    run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk); chk_idle("idle_c");

    // backpressure with a second block waiting
    pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
    ea = aes_enc(pa, ka);
    out_ready = 1'b0;
    run_block(pa, ka, ea);
    in_valid = 1'b1; in_block = pb; in_key = kb;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_cipher_stable", out_cipher, ea);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_round", round_o, 128'd10);
      chk("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("bp_idle");
    run_block(pb, kb, aes_enc(pb, kb));
    @(negedge clk);

    // reset during round 5
    in_valid = 1'b1; in_block = rnd128(); in_key = rnd128();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_round", round_o, 128'd5);
    resetn = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_reset_no_valid", out_valid, 1'b0);
      chk("post_reset_round", round_o, 128'd0);
    end
    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32);
    @(negedge clk);

    // back-to-back random blocks, out_ready high throughout
    for (int n = 0; n < 4; n++) begin
      pa = rnd128(); ka = rnd128();
      prev_acc = acc_cyc;
      run_block(pa, ka, aes_enc(pa, ka));
      if (n > 0) chk("accept_spacing", 128'(acc_cyc - prev_acc), 128'd12);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
